// File: rtl/bp_pkg.sv
// Shared types and constants for the branch target buffer.
package bp_pkg;

    localparam int unsigned BP_IDX_W = 3;
    localparam int unsigned BP_TAG_W = 32 - BP_IDX_W - 2;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    typedef struct packed {
        logic                valid;
        logic [BP_TAG_W-1:0] tag;
        logic [1:0]          ctr;
        logic [31:0]         target;
    } btb_entry_t;

endpackage

// File: rtl/sat_counter2.sv
// 2-bit saturating up/down counter, next-value only (no state).
module sat_counter2
    import bp_pkg::*;
(
    input  logic [1:0] ctr_i,
    input  logic       taken_i,
    output logic [1:0] ctr_o
);

    always_comb begin
        ctr_o = ctr_i;
        if (taken_i) begin
            if (ctr_i != CTR_ST) ctr_o = ctr_i + 2'd1;
        end else begin
            if (ctr_i != CTR_SNT) ctr_o = ctr_i - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: fetch lookup, MEM-stage training,
// mispredict flush/recovery and branch statistics.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int unsigned IDX_W     = BP_IDX_W,
    parameter logic [1:0]  RESET_CTR = CTR_WNT
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [31:0]      lk_pc,
    output logic             lk_predict,
    output logic [IDX_W-1:0] lk_index,
    output logic [31:0]      lk_target,
    input  logic             upd_en,
    input  logic [31:0]      upd_pc,
    input  logic [IDX_W-1:0] upd_index,
    input  logic             upd_predict,
    input  logic [31:0]      upd_pred_target,
    input  logic             upd_taken,
    input  logic [31:0]      upd_target,
    input  logic [31:0]      upd_pc_plus4,
    output logic             mispredict,
    output logic [31:0]      recover_pc,
    output logic [31:0]      br_count,
    output logic [31:0]      mp_count
);

    localparam int unsigned Entries = 2 ** IDX_W;
    localparam int unsigned TagW    = 32 - IDX_W - 2;

    btb_entry_t  tbl_q [Entries];
    btb_entry_t  tbl_d [Entries];
    logic [31:0] br_count_q, br_count_d;
    logic [31:0] mp_count_q, mp_count_d;

    btb_entry_t  lk_entry, upd_entry;
    logic        lk_hit, upd_hit;
    logic [TagW-1:0] upd_tag;
    logic [1:0]  ctr_next;

    // Byte-offset and index bits of the PCs are not part of the tag.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{lk_pc[1:0], upd_pc[IDX_W+1:0]};

    // Lookup reads the registered table only, so same-cycle writes are not bypassed.
    assign lk_index   = lk_pc[IDX_W+1:2];
    assign lk_entry   = tbl_q[lk_index];
    assign lk_hit     = lk_entry.valid && (lk_entry.tag == lk_pc[31:IDX_W+2]);
    assign lk_predict = lk_hit && lk_entry.ctr[1];
    assign lk_target  = lk_predict ? lk_entry.target : 32'h0;

    assign upd_entry = tbl_q[upd_index];
    assign upd_tag   = upd_pc[31:IDX_W+2];
    assign upd_hit   = upd_entry.valid && (upd_entry.tag == upd_tag);

    sat_counter2 u_sat_counter2 (
        .ctr_i   (upd_entry.ctr),
        .taken_i (upd_taken),
        .ctr_o   (ctr_next)
    );

    always_comb begin
        mispredict = 1'b0;
        recover_pc = 32'h0;
        if (nRST && upd_en) begin
            mispredict = (upd_predict != upd_taken) ||
                         (upd_taken && (upd_pred_target != upd_target));
            recover_pc = upd_taken ? upd_target : upd_pc_plus4;
        end
    end

    always_comb begin
        tbl_d = tbl_q;
        if (upd_en) begin
            if (upd_hit) begin
                tbl_d[upd_index].ctr = ctr_next;
                if (upd_taken) tbl_d[upd_index].target = upd_target;
            end else if (upd_taken) begin
                tbl_d[upd_index] = '{valid: 1'b1, tag: upd_tag, ctr: CTR_WT, target: upd_target};
            end
        end
    end

    always_comb begin
        br_count_d = br_count_q;
        mp_count_d = mp_count_q;
        if (upd_en) br_count_d = br_count_q + 32'd1;
        if (mispredict) mp_count_d = mp_count_q + 32'd1;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < Entries; i++) begin
                tbl_q[i] <= '{valid: 1'b0, tag: '0, ctr: RESET_CTR, target: 32'h0};
            end
            br_count_q <= 32'h0;
            mp_count_q <= 32'h0;
        end else begin
            tbl_q      <= tbl_d;
            br_count_q <= br_count_d;
            mp_count_q <= mp_count_d;
        end
    end

    assign br_count = br_count_q;
    assign mp_count = mp_count_q;

endmodule
